// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the toggle-handshake CDC launcher and its
// destination-side counterpart.
//   state_t             : launcher FSM encoding (IDLE / LAUNCH / WAIT_ACK)
//   DEFAULT_BUS_WIDTH   : default width of the crossed word
//   DEFAULT_NUM_STAGES  : default depth of the ack synchronizer
package cdc_handshake_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LAUNCH   = 2'b01,
    WAIT_ACK = 2'b10
  } state_t;

  localparam int DEFAULT_BUS_WIDTH  = 4;
  localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/cdc_ack_sync.sv
// Single-bit multi-flop synchronizer for the toggle ack coming back from the
// destination domain.
//   clk       : source-domain clock
//   rst_n     : asynchronous active-low reset, clears the whole chain
//   ack_async : toggle ack, asynchronous to clk (feeds the first flop directly)
//   ack_sync  : last stage of the chain, safe to use in the clk domain
module cdc_ack_sync
  import cdc_handshake_tx_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ack_async,
  output logic ack_sync
);

  if (NUM_STAGES < 2) begin : g_bad_depth
    $error("cdc_ack_sync: NUM_STAGES must be at least 2");
  end

  logic [NUM_STAGES-1:0] sync_q;

  // No logic ahead of the first flop: the asynchronous input lands straight
  // on sync_q[0] so only that flop can go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], ack_async};
    end
  end

  assign ack_sync = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain launcher for a multi-bit clock-domain crossing using a
// 2-phase (toggle) req/ack handshake.
//   CLK       : source-domain clock (only clock in the block)
//   RST       : asynchronous active-low reset
//   IN_DATA   : word to transfer, sampled only while IN_READY=1
//   IN_VALID  : IN_DATA valid this cycle
//   IN_READY  : block can accept a word (state is IDLE)
//   ACK_ASYNC : toggle ack from the destination, asynchronous to CLK
//   REQ_OUT   : toggle request to the destination, straight from a flop
//   DATA_OUT  : launched word, straight from flops, stable for the transfer
//   BUSY      : transfer in flight (state is not IDLE)
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 ACK_ASYNC,
  output logic                 REQ_OUT,
  output logic [BUS_WIDTH-1:0] DATA_OUT,
  output logic                 BUSY
);

  state_t               state;
  logic                 req_q;
  logic [BUS_WIDTH-1:0] data_q;
  logic                 ack_sync;

  cdc_ack_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .clk      (CLK),
    .rst_n    (RST),
    .ack_async(ACK_ASYNC),
    .ack_sync (ack_sync)
  );

  // LAUNCH sits between data capture and the req toggle so the bus has a
  // full cycle to settle before the destination can see a new request.
  // WAIT_ACK ends when the synchronized ack parity catches up with req; an
  // ack that already matches on entry simply exits on the next edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            data_q <= IN_DATA;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          req_q <= ~req_q;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ack_sync == req_q) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign REQ_OUT  = req_q;
  assign DATA_OUT = data_q;
  assign IN_READY = (state == IDLE);
  assign BUSY     = (state != IDLE);

endmodule
